cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_ACTIVE, default 160, pixels per line.
REQ-002 Parameter V_ACTIVE, default 120, lines per frame.
REQ-003 Parameter BPC, default 1, output bits per colour channel, legal 1..4; DW = 3*BPC.
REQ-004 Parameter AW, default 15, address width, SHALL satisfy 2^AW >= H_ACTIVE*V_ACTIVE.
REQ-005 pclk  in  1  camera pixel clock; sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  capture enable, sampled only at frame start.
REQ-008 fmt  in  1  byte format: 0 = RGB444 (xxxxRRRR, GGGGBBBB), 1 = RGB565 (RRRRRGGG, GGGBBBBB).
REQ-009 vsync, href  in  1 each  camera sync; data valid only when href=1 and vsync=0.
REQ-010 data  in  8  camera byte.
REQ-011 mem_px_addr  out  AW  write address; mem_px_data  out  DW  packed {R,G,B}, MSB first; px_wr  out  1  write strobe.
REQ-012 frame_done  out  1  one-cycle completion pulse; busy  out  1  high in CAPTURE; line_err  out  1  sticky line-length error.

Function
REQ-013 FSM states: WAIT_VS, CAPTURE. After reset, state = WAIT_VS.
REQ-014 WAIT_VS -> CAPTURE on the cycle where vsync is sampled 0 and was 1 on the previous cycle (falling edge), and en=1; otherwise remain in WAIT_VS.
REQ-015 CAPTURE -> WAIT_VS when vsync is sampled 1, or one cycle after the write to address H_ACTIVE*V_ACTIVE-1; frame_done SHALL pulse on that transition.
REQ-016 In CAPTURE, a byte phase toggle SHALL alternate first/second byte on every valid byte. The phase SHALL clear to "first" on every href falling edge.
REQ-017 First byte is held in a register. On the second byte, the pixel is formed from the top BPC bits of each channel, per fmt. For RGB565, green uses the 6-bit concatenation.
REQ-018 px_wr SHALL pulse high for exactly one cycle, on the cycle after the second byte is sampled. mem_px_addr and mem_px_data SHALL be valid in that same cycle; latency is 1 pclk.
REQ-019 The first write of each frame SHALL use address 0. Each subsequent write uses the previous address +1, linear and row-major.
REQ-020 Writes beyond address H_ACTIVE*V_ACTIVE-1 SHALL be suppressed; the address never wraps within a frame.
REQ-021 A column counter SHALL count pixels per line and clear on href falling edge. A row counter SHALL increment on href falling edge and clear at frame start.
REQ-022 Pixels with column >= H_ACTIVE SHALL not be written, and the address SHALL not advance for them.
REQ-023 An odd trailing byte at href falling edge SHALL be discarded; no partial write.
REQ-024 vsync rising mid-line SHALL abort the frame immediately. Any pending px_wr for an already-completed pixel still issues.
REQ-025 en deasserted during CAPTURE SHALL not stop the current frame.

Reset
REQ-026 On rst: state = WAIT_VS, mem_px_addr = 0, mem_px_data = 0, px_wr = 0, frame_done = 0, busy = 0, line_err = 0; counters, byte phase and stored vsync = 0.
REQ-027 Reset mid-frame SHALL require a fresh vsync falling edge before capture resumes.

Configuration
REQ-028 Macro CAM_CAPTURE_LINE_CHECK_EN:
- Defined: at each href falling edge in CAPTURE, line_err SHALL set if the column count != H_ACTIVE or a byte was odd. line_err clears only on rst.
- Undefined: line_err SHALL be tied to 0, and no check logic is synthesised.

Structure
REQ-029 Package cam_pkg SHALL hold:
- the state encoding (WAIT_VS, CAPTURE)
- the fmt codes (FMT_RGB444 = 0, FMT_RGB565 = 1)
- the QQVGA defaults 160/120
REQ-030 One sub-module, cam_px_pack, SHALL perform the combinational two-byte to DW-bit conversion per fmt and BPC.

Verification
REQ-031 Default parameters, fmt=0, en=1, one full 160x120 frame of bytes 0x0F,0xF0 -> 19200 px_wr pulses, addresses 0..19199, data 3'b110, one frame_done.
REQ-032 BPC=4, fmt=1, byte pair 0xF8,0x1F -> mem_px_data = 12'hF0F.
REQ-033 Line of 161 pixels, CAM_CAPTURE_LINE_CHECK_EN defined -> 160 writes, line_err=1. With the macro undefined -> line_err=0.
REQ-034 vsync asserted after line 10 -> frame_done pulse, last address 1599, no further px_wr until the next vsync falling edge.
REQ-035 rst asserted at address 500 -> all outputs 0 the next cycle; the next frame restarts at address 0 only after a vsync falling edge.
REQ-036 en=0 at vsync falling edge -> zero px_wr for that frame, busy stays 0.

Source files
------------

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state encoding, byte-format codes and QQVGA geometry for cam_capture
package cam_pkg;

    typedef enum logic {
        WAIT_VS = 1'b0,
        CAPTURE = 1'b1
    } cam_state_t;

    localparam logic FMT_RGB444 = 1'b0;
    localparam logic FMT_RGB565 = 1'b1;

    localparam int QQVGA_H = 160;
    localparam int QQVGA_V = 120;

endpackage

// File: rtl/cam_px_pack.sv
// rtl/cam_px_pack.sv - combinational two-byte to {R,G,B} pixel packer, keeps top BPC bits per channel
module cam_px_pack
    import cam_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [7:0]       i_byte0,
    input  logic [7:0]       i_byte1,
    input  logic             i_fmt,
    output logic [3*BPC-1:0] o_px
);

    logic [4:0] w_r5;
    logic [5:0] w_g6;
    logic [4:0] w_b5;
    logic       w_unused_lsbs;

    // Left-justify every channel into a 5/6-bit field so one MSB slice serves both formats
    always_comb begin
        w_r5 = '0;
        w_g6 = '0;
        w_b5 = '0;
        if (i_fmt == FMT_RGB565) begin
            w_r5 = i_byte0[7:3];
            w_g6 = {i_byte0[2:0], i_byte1[7:5]};
            w_b5 = i_byte1[4:0];
        end else begin
            w_r5 = {i_byte0[3:0], 1'b0};
            w_g6 = {i_byte1[7:4], 2'b00};
            w_b5 = {i_byte1[3:0], 1'b0};
        end
        o_px = {w_r5[4 -: BPC], w_g6[5 -: BPC], w_b5[4 -: BPC]};
    end

    // Channel bits below the kept BPC MSBs are dropped on purpose
    assign w_unused_lsbs = ^{w_r5, w_g6, w_b5};

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - camera byte-stream frame capture into linear pixel memory; optional CAM_CAPTURE_LINE_CHECK_EN
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = QQVGA_H,
    parameter int V_ACTIVE = QQVGA_V,
    parameter int BPC      = 1,
    parameter int AW       = 15
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    input  logic             fmt,
    input  logic             vsync,
    input  logic             href,
    input  logic [7:0]       data,
    output logic [AW-1:0]    mem_px_addr,
    output logic [3*BPC-1:0] mem_px_data,
    output logic             px_wr,
    output logic             frame_done,
    output logic             busy,
    output logic             line_err
);

    localparam int DW   = 3 * BPC;
    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam int CW   = $clog2(H_ACTIVE + 2);
    localparam int RW   = $clog2(V_ACTIVE + 2);

    // Counters saturate one past the active size so over-long lines stay distinguishable
    localparam logic [CW-1:0] COL_SAT = CW'(H_ACTIVE + 1);
    localparam logic [RW-1:0] ROW_SAT = RW'(V_ACTIVE + 1);

    cam_state_t r_state;
    cam_state_t w_next_state;

    logic          r_vsync_d;
    logic          r_href_d;
    logic          r_phase;
    logic [7:0]    r_byte0;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW:0]   r_wr_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_px_wr;
    logic          r_frame_done;

    logic          w_vs_fall;
    logic          w_href_fall;
    logic          w_capture;
    logic          w_byte_vld;
    logic          w_in_window;
    logic          w_do_wr;
    logic          w_last_wr;
    logic          w_frame_end;
    logic [DW-1:0] w_px;

    assign w_vs_fall   = r_vsync_d & ~vsync;
    assign w_href_fall = r_href_d & ~href;
    assign w_capture   = (r_state == CAPTURE);
    assign w_byte_vld  = w_capture & href & ~vsync;
    assign w_in_window = (r_col < CW'(H_ACTIVE)) && (r_row < RW'(V_ACTIVE))
                         && (r_wr_cnt < (AW+1)'(NPIX));
    assign w_do_wr     = w_byte_vld & r_phase & w_in_window;
    assign w_last_wr   = r_px_wr && (r_addr == AW'(NPIX - 1));
    assign w_frame_end = w_capture && (w_next_state == WAIT_VS);

    cam_px_pack #(
        .BPC (BPC)
    ) u_pack (
        .i_byte0 (r_byte0),
        .i_byte1 (data),
        .i_fmt   (fmt),
        .o_px    (w_px)
    );

    // State register
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= WAIT_VS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: arm on a vsync falling edge with enable, leave on vsync or after the final pixel
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_VS: begin
                if (w_vs_fall && en) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (vsync || w_last_wr) begin
                    w_next_state = WAIT_VS;
                end
            end
            default: w_next_state = WAIT_VS;
        endcase
    end

    // Byte pairing, line/row counting and the registered pixel write port
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vsync_d    <= 1'b0;
            r_href_d     <= 1'b0;
            r_phase      <= 1'b0;
            r_byte0      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_wr_cnt     <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_px_wr      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            r_href_d     <= href;
            r_px_wr      <= w_do_wr;
            r_frame_done <= w_frame_end;

            if (w_do_wr) begin
                r_addr   <= r_wr_cnt[AW-1:0];
                r_data   <= w_px;
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end

            if (!w_capture) begin
                // Idle between frames keeps everything at frame-start values
                r_phase  <= 1'b0;
                r_col    <= '0;
                r_row    <= '0;
                r_wr_cnt <= '0;
            end else if (w_href_fall) begin
                // An unpaired trailing byte is simply forgotten here
                r_phase <= 1'b0;
                r_col   <= '0;
                if (r_row != ROW_SAT) begin
                    r_row <= r_row + 1'b1;
                end
            end else if (w_byte_vld) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_byte0 <= data;
                end else if (r_col != COL_SAT) begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

`ifdef CAM_CAPTURE_LINE_CHECK_EN
    logic r_line_err;

    // Sticky flag for any line that ends with the wrong pixel count or a dangling byte
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_line_err <= 1'b0;
        end else if (w_capture && w_href_fall && ((r_col != CW'(H_ACTIVE)) || r_phase)) begin
            r_line_err <= 1'b1;
        end
    end

    assign line_err = r_line_err;
`else
    assign line_err = 1'b0;
`endif

    assign mem_px_addr = r_addr;
    assign mem_px_data = r_data;
    assign px_wr       = r_px_wr;
    assign frame_done  = r_frame_done;
    assign busy        = w_capture;

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - directed self-checking bench for cam_capture (BPC=1 and BPC=4 instances)
module tb_cam_capture;

    logic        pclk;
    logic        rst;
    logic        en;
    logic        fmt;
    logic        vsync;
    logic        href;
    logic [7:0]  data;

    logic [14:0] mem_px_addr;
    logic [2:0]  mem_px_data;
    logic        px_wr;
    logic        frame_done;
    logic        busy;
    logic        line_err;

    logic [14:0] addr4;
    logic [11:0] data4;
    logic        wr4;
    logic        done4;
    logic        busy4;
    logic        lerr4;

    int n_chk = 0;
    int n_err = 0;

    int n_wr = 0;
    int n_done = 0;
    int n_addr_err = 0;
    int n_data_err = 0;
    int n_b2b = 0;
    logic [14:0] exp_addr = '0;
    logic [14:0] last_addr = '0;
    logic        prev_wr = 1'b0;

    logic [2:0]  exp_data = 3'b110;
    logic [11:0] exp_data4 = 12'hFF0;

    int base_wr;
    int base_done;
    logic exp_lerr;

    cam_capture u_dut (
        .pclk        (pclk),
        .rst         (rst),
        .en          (en),
        .fmt         (fmt),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .busy        (busy),
        .line_err    (line_err)
    );

    cam_capture #(
        .BPC (4)
    ) u_dut4 (
        .pclk        (pclk),
        .rst         (rst),
        .en          (en),
        .fmt         (fmt),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .mem_px_addr (addr4),
        .mem_px_data (data4),
        .px_wr       (wr4),
        .frame_done  (done4),
        .busy        (busy4),
        .line_err    (lerr4)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (px_wr) begin
            n_wr++;
            if (mem_px_addr !== exp_addr) n_addr_err++;
            if (mem_px_data !== exp_data) n_data_err++;
            if (wr4 !== 1'b1 || addr4 !== exp_addr || data4 !== exp_data4) n_data_err++;
            if (prev_wr) n_b2b++;
            last_addr = mem_px_addr;
            exp_addr  = exp_addr + 15'd1;
        end
        if (frame_done) begin
            n_done++;
            exp_addr = '0;
        end
        if (rst) exp_addr = '0;
        prev_wr = px_wr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic vs_pulse();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (3) step();
    endtask

    task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1, input bit odd);
        href = 1'b1;
        for (int i = 0; i < npix; i++) begin
            data = b0;
            step();
            data = b1;
            step();
        end
        if (odd) begin
            data = b0;
            step();
        end
        href = 1'b0;
        data = 8'h00;
        repeat (4) step();
    endtask

    task automatic end_frame();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (4) step();
    endtask

    initial begin
`ifdef CAM_CAPTURE_LINE_CHECK_EN
        exp_lerr = 1'b1;
`else
        exp_lerr = 1'b0;
`endif
        rst   = 1'b1;
        en    = 1'b1;
        fmt   = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        data  = 8'h00;
        repeat (3) step();

        chk("rst_px_wr", px_wr, 0);
        chk("rst_addr", mem_px_addr, 0);
        chk("rst_data", mem_px_data, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_err", line_err, 0);
        rst = 1'b0;
        step();

        // Full RGB444 frame
        base_wr = n_wr; base_done = n_done;
        vs_pulse();
        chk("f1_busy", busy, 1);
        for (int l = 0; l < 120; l++) send_line(160, 8'h0F, 8'hF0, 1'b0);
        chk("f1_writes", n_wr - base_wr, 19200);
        chk("f1_last_addr", last_addr, 19199);
        chk("f1_done", n_done - base_done, 1);
        chk("f1_busy_after", busy, 0);
        chk("f1_addr_err", n_addr_err, 0);
        chk("f1_data_err", n_data_err, 0);
        chk("f1_line_err", line_err, 0);

        // RGB565, an over-long line, an odd-byte line, then a normal short line
        fmt = 1'b1; exp_data = 3'b101; exp_data4 = 12'hF0F;
        base_wr = n_wr; base_done = n_done;
        vs_pulse();
        send_line(161, 8'hF8, 8'h1F, 1'b0);
        chk("long_writes", n_wr - base_wr, 160);
        chk("long_last_addr", last_addr, 159);
        chk("long_line_err", line_err, exp_lerr);
        send_line(4, 8'hF8, 8'h1F, 1'b1);
        send_line(3, 8'hF8, 8'h1F, 1'b0);
        chk("odd_writes", n_wr - base_wr, 167);
        chk("odd_last_addr", last_addr, 166);
        end_frame();
        chk("odd_done", n_done - base_done, 1);
        chk("f2_data_err", n_data_err, 0);

        // vsync abort after ten lines
        fmt = 1'b0; exp_data = 3'b110; exp_data4 = 12'hFF0;
        base_wr = n_wr; base_done = n_done;
        vs_pulse();
        for (int l = 0; l < 10; l++) send_line(160, 8'h0F, 8'hF0, 1'b0);
        vsync = 1'b1;
        send_line(20, 8'h0F, 8'hF0, 1'b0);
        chk("abort_writes", n_wr - base_wr, 1600);
        chk("abort_last_addr", last_addr, 1599);
        chk("abort_done", n_done - base_done, 1);
        chk("abort_busy", busy, 0);

        // Capture disabled at frame start
        en = 1'b0;
        base_wr = n_wr; base_done = n_done;
        vs_pulse();
        chk("en0_busy", busy, 0);
        send_line(160, 8'h0F, 8'hF0, 1'b0);
        send_line(160, 8'h0F, 8'hF0, 1'b0);
        end_frame();
        chk("en0_writes", n_wr - base_wr, 0);
        chk("en0_done", n_done - base_done, 0);

        // Enable dropped mid-frame does not stop the frame
        en = 1'b1;
        base_wr = n_wr; base_done = n_done;
        vs_pulse();
        en = 1'b0;
        send_line(160, 8'h0F, 8'hF0, 1'b0);
        send_line(160, 8'h0F, 8'hF0, 1'b0);
        chk("endrop_busy", busy, 1);
        chk("endrop_writes", n_wr - base_wr, 320);
        chk("endrop_last_addr", last_addr, 319);
        end_frame();
        chk("endrop_done", n_done - base_done, 1);
        en = 1'b1;

        // Reset while address 500 is being written
        base_wr = n_wr;
        vs_pulse();
        for (int l = 0; l < 3; l++) send_line(160, 8'h0F, 8'hF0, 1'b0);
        href = 1'b1;
        for (int i = 0; i < 21; i++) begin
            data = 8'h0F; step();
            data = 8'hF0; step();
        end
        chk("pre_rst_wr", px_wr, 1);
        chk("pre_rst_addr", mem_px_addr, 500);
        chk("pre_rst_line_err", line_err, exp_lerr);
        rst = 1'b1; href = 1'b0; data = 8'h00;
        step();
        chk("mid_rst_px_wr", px_wr, 0);
        chk("mid_rst_addr", mem_px_addr, 0);
        chk("mid_rst_data", mem_px_data, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_line_err", line_err, 0);
        rst = 1'b0;
        step();
        base_wr = n_wr;
        send_line(160, 8'h0F, 8'hF0, 1'b0);
        chk("post_rst_no_vs_writes", n_wr - base_wr, 0);
        chk("post_rst_no_vs_busy", busy, 0);
        base_done = n_done;
        vs_pulse();
        send_line(160, 8'h0F, 8'hF0, 1'b0);
        chk("restart_writes", n_wr - base_wr, 160);
        chk("restart_last_addr", last_addr, 159);
        end_frame();
        chk("restart_done", n_done - base_done, 1);

        chk("all_addr_err", n_addr_err, 0);
        chk("all_data_err", n_data_err, 0);
        chk("all_back_to_back", n_b2b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
